// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Power-up / lock-loss reset controller for the PLL clock manager. It runs on the
//   board reference clock, which also feeds the PLL, so it keeps running while the PLL
//   is unlocked. It holds the PLL in reset, waits for a stable lock, then releases the
//   system reset followed by the cipher-core reset. The sequence restarts on lock loss,
//   and a core soft-reset request re-resets only the cipher core.
//
// Ports
//   clk          board reference clock (same net as PLL clkin)
//   rst_n        asynchronous active-low reset
//   pll_locked   PLL lock indication, asynchronous to clk
//   soft_rst_req one-cycle request to re-reset the cipher core (honoured in RUN only)
//   pll_areset   active-high PLL reset
//   sys_rst_n    active-low system reset, synchronous to clk
//   core_rst_n   active-low cipher-core reset, synchronous to clk
//   ready        high only while the sequence is complete (RUN)
//   lock_retries saturating count of lock timeouts
//   state_o      encoded FSM state for debug
module reset_sequencer #(
   parameter int unsigned PLL_RST_CYCLES     = 16,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned LOCK_TIMEOUT       = 65536,
   parameter int unsigned SEQ_GAP            = 64,
   parameter int unsigned CNT_W              = 17
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       soft_rst_req,
   output logic       pll_areset,
   output logic       sys_rst_n,
   output logic       core_rst_n,
   output logic       ready,
   output logic [7:0] lock_retries,
   output logic [2:0] state_o
);

   localparam logic [2:0] StPllRst   = 3'd0;
   localparam logic [2:0] StWaitLock = 3'd1;
   localparam logic [2:0] StRelSys   = 3'd2;
   localparam logic [2:0] StRelCore  = 3'd3;
   localparam logic [2:0] StRun      = 3'd4;
   localparam logic [2:0] StCoreRst  = 3'd5;

   localparam logic [CNT_W-1:0] PllRstLast  = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GapLast     = CNT_W'(SEQ_GAP - 1);

   logic [1:0]       sync_q;
   logic             lk;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] stable_q, stable_d;
   logic [7:0]       retries_q, retries_d;
   logic             pll_areset_q, pll_areset_d;
   logic             sys_rst_n_q, sys_rst_n_d;
   logic             core_rst_n_q, core_rst_n_d;
   logic             ready_q, ready_d;

   assign lk = sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], pll_locked};
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      stable_d  = '0;
      retries_d = retries_q;
      unique case (state_q)
         StPllRst: begin
            if (cnt_q == PllRstLast) state_d = StWaitLock;
         end
         StWaitLock: begin
            // Lock loss here only restarts the stability window.
            if (lk) stable_d = stable_q + CNT_W'(1);
            if (lk && (stable_q == StableLast)) begin
               state_d = StRelSys;
            end else if (cnt_q == TimeoutLast) begin
               state_d = StPllRst;
               if (retries_q != 8'hff) retries_d = retries_q + 8'd1;
            end
         end
         StRelSys: begin
            if (!lk)                     state_d = StPllRst;
            else if (cnt_q == GapLast)   state_d = StRelCore;
         end
         StRelCore: begin
            cnt_d = '0;
            if (!lk) state_d = StPllRst;
            else     state_d = StRun;
         end
         StRun: begin
            cnt_d = '0;
            // Lock loss outranks a simultaneous soft-reset request.
            if (!lk)               state_d = StPllRst;
            else if (soft_rst_req) state_d = StCoreRst;
         end
         StCoreRst: begin
            if (!lk)                   state_d = StPllRst;
            else if (cnt_q == GapLast) state_d = StRelCore;
         end
         default: state_d = StPllRst;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   // Outputs are decoded from the next state so they change on the same edge as the
   // state register while still being driven straight from flops.
   always_comb begin
      pll_areset_d = (state_d == StPllRst);
      sys_rst_n_d  = (state_d == StRelSys) || (state_d == StRelCore) ||
                     (state_d == StRun)    || (state_d == StCoreRst);
      core_rst_n_d = (state_d == StRelCore) || (state_d == StRun);
      ready_d      = (state_d == StRun);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StPllRst;
         cnt_q        <= '0;
         stable_q     <= '0;
         retries_q    <= 8'd0;
         pll_areset_q <= 1'b1;
         sys_rst_n_q  <= 1'b0;
         core_rst_n_q <= 1'b0;
         ready_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         stable_q     <= stable_d;
         retries_q    <= retries_d;
         pll_areset_q <= pll_areset_d;
         sys_rst_n_q  <= sys_rst_n_d;
         core_rst_n_q <= core_rst_n_d;
         ready_q      <= ready_d;
      end
   end

   assign pll_areset   = pll_areset_q;
   assign sys_rst_n    = sys_rst_n_q;
   assign core_rst_n   = core_rst_n_q;
   assign ready        = ready_q;
   assign lock_retries = retries_q;
   assign state_o      = state_q;

endmodule
